// File: rtl/queue_arbiter_pkg.sv
// Shared parameters and helpers for the queue arbiter and related port arbiters.
// Packet width and default port count live here so every stage agrees on them.
package queue_arbiter_pkg;

  localparam int PACKET_WIDTH      = 32;
  localparam int DEFAULT_NUM_PORTS = 4;
  localparam int DEFAULT_PORT_BITS = 2;

  // Modulo increment that wraps explicitly, so non-power-of-two port counts stay in range.
  function automatic int wrap_inc(input int idx, input int modulus);
    return (idx + 1 >= modulus) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/queue_arbiter_if.sv
// Valid/ready packet bundle between the producers, the arbiter and the packet queue.
// The arbiter uses the slave modport; producers and the queue side use master.
interface queue_arbiter_if
  import queue_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int PORT_BITS = DEFAULT_PORT_BITS,
  parameter int PKT_W     = PACKET_WIDTH
);

  logic [NUM_PORTS-1:0]       RECEIVE_PC_VALID;
  logic [NUM_PORTS*PKT_W-1:0] RECEIVE_PC_DATA;
  logic [NUM_PORTS-1:0]       RECEIVE_PC_READY;
  logic                       SEND_PC_VALID;
  logic [PKT_W-1:0]           SEND_PC_DATA;
  logic                       SEND_PC_READY;
  logic [PORT_BITS-1:0]       SEND_PC_SRC;

  modport slave (
    input  RECEIVE_PC_VALID, RECEIVE_PC_DATA, SEND_PC_READY,
    output RECEIVE_PC_READY, SEND_PC_VALID, SEND_PC_DATA, SEND_PC_SRC
  );

  modport master (
    output RECEIVE_PC_VALID, RECEIVE_PC_DATA, SEND_PC_READY,
    input  RECEIVE_PC_READY, SEND_PC_VALID, SEND_PC_DATA, SEND_PC_SRC
  );

endinterface

// File: rtl/queue_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Kept free of state so other port arbiters can reuse it.
module rr_picker
  import queue_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int PORT_BITS = DEFAULT_PORT_BITS
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_BITS-1:0] ptr,
  output logic                 any,
  output logic [PORT_BITS-1:0] grant
);

  logic [NUM_PORTS-1:0] rotated;
  int                   idx;

  // Bit k of rotated is the request at (ptr + k) mod NUM_PORTS.
  assign rotated = NUM_PORTS'({req, req} >> ptr);

  always_comb begin
    any   = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_PORTS) begin
          idx = idx - NUM_PORTS;
        end
        any   = 1'b1;
        grant = PORT_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/queue_arbiter.sv
// Round-robin merge of NUM_PORTS producer channels into one registered output stage
// feeding the packet queue; one packet per cycle, no drops, bounded wait per requester.
module queue_arbiter
  import queue_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int PORT_BITS = DEFAULT_PORT_BITS
) (
  input  logic          CLK,
  input  logic          RST_N,
  queue_arbiter_if.slave bus
);

  logic                    load;
  logic                    any;
  logic [PORT_BITS-1:0]    grant;
  logic [NUM_PORTS-1:0]    recv_ready;

  logic                    send_valid_q, send_valid_d;
  logic [PACKET_WIDTH-1:0] send_data_q,  send_data_d;
  logic [PORT_BITS-1:0]    send_src_q,   send_src_d;
  logic [PORT_BITS-1:0]    ptr_q,        ptr_d;

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_BITS (PORT_BITS)
  ) u_picker (
    .req   (bus.RECEIVE_PC_VALID),
    .ptr   (ptr_q),
    .any   (any),
    .grant (grant)
  );

  assign load = !send_valid_q || bus.SEND_PC_READY;

  // Ready is gated by RST_N so producers see no acceptance while reset is held.
  always_comb begin
    send_valid_d = send_valid_q;
    send_data_d  = send_data_q;
    send_src_d   = send_src_q;
    ptr_d        = ptr_q;
    recv_ready   = '0;
    if (load) begin
      send_valid_d = any;
      if (any) begin
        send_data_d       = bus.RECEIVE_PC_DATA[int'(grant)*PACKET_WIDTH +: PACKET_WIDTH];
        send_src_d        = grant;
        ptr_d             = PORT_BITS'(wrap_inc(int'(grant), NUM_PORTS));
        recv_ready[grant] = RST_N;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      send_valid_q <= 1'b0;
      send_data_q  <= '0;
      send_src_q   <= '0;
      ptr_q        <= '0;
    end else begin
      send_valid_q <= send_valid_d;
      send_data_q  <= send_data_d;
      send_src_q   <= send_src_d;
      ptr_q        <= ptr_d;
    end
  end

  assign bus.RECEIVE_PC_READY = recv_ready;
  assign bus.SEND_PC_VALID    = send_valid_q;
  assign bus.SEND_PC_DATA     = send_data_q;
  assign bus.SEND_PC_SRC      = send_src_q;

endmodule

// File: tb/tb_queue_arbiter.sv
// Bench for queue_arbiter: directed vector table, reset/fairness sequences,
// and a random soak checked against per-source expected-order queues.
module tb_queue_arbiter;
  import queue_arbiter_pkg::*;

  localparam int NP = 4;
  localparam int PB = 2;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic        sready;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [1:0]  exp_src;
    logic [31:0] exp_data;
    logic [1:0]  exp_ptr;
  } vec_t;

  logic CLK;
  logic RST_N;
  int   checks;
  int   failures;
  int   pending [NP];
  int   startAt [NP];
  vec_t vecs [$];

  queue_arbiter_if #(.NUM_PORTS(NP), .PORT_BITS(PB), .PKT_W(PACKET_WIDTH)) bus ();

  queue_arbiter #(.NUM_PORTS(NP), .PORT_BITS(PB)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] chanData(input int i);
    return {16'hC0DE, 8'(i), 8'hA5};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic rst_n, input logic [3:0] valid, input logic sready,
                        input logic [3:0] exp_ready, input logic exp_valid, input logic [1:0] exp_src,
                        input logic [31:0] exp_data, input logic [1:0] exp_ptr);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.sready = sready; v.exp_ready = exp_ready;
    v.exp_valid = exp_valid; v.exp_src = exp_src; v.exp_data = exp_data; v.exp_ptr = exp_ptr;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input int n, input vec_t v);
    RST_N = v.rst_n;
    bus.RECEIVE_PC_VALID = v.valid;
    bus.SEND_PC_READY = v.sready;
    for (int i = 0; i < NP; i++) bus.RECEIVE_PC_DATA[i*32 +: 32] = chanData(i);
    #1;
    checkOutput($sformatf("vec%0d_ready", n), bus.RECEIVE_PC_READY, v.exp_ready);
    @(posedge CLK);
    #1;
    checkOutput($sformatf("vec%0d_send_valid", n), bus.SEND_PC_VALID, v.exp_valid);
    checkOutput($sformatf("vec%0d_send_src", n), bus.SEND_PC_SRC, v.exp_src);
    checkOutput($sformatf("vec%0d_send_data", n), bus.SEND_PC_DATA, v.exp_data);
    checkOutput($sformatf("vec%0d_ptr", n), dut.ptr_q, v.exp_ptr);
  endtask

  task automatic doReset();
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  // Cycle-level producer model; pending/startAt select how many packets each source sends and when.
  task automatic runTraffic(input string name, input int maxCycles, input bit randomReady, input bit randomGaps);
    logic [31:0] curData [NP];
    bit          offering [NP];
    int          seqNo [NP];
    int          waitCnt [NP];
    logic [31:0] expQ [NP][$];
    int          maxWait, delivered, total;
    bit          done;
    logic [3:0]  rdy;
    logic        sv, sr;
    logic [1:0]  ss;
    logic [31:0] sd, expData;
    total = 0; maxWait = 0; delivered = 0; done = 1'b0;
    for (int i = 0; i < NP; i++) begin
      total += pending[i];
      offering[i] = 1'b0; seqNo[i] = 0; waitCnt[i] = 0; curData[i] = '0;
      expQ[i].delete();
    end
    bus.RECEIVE_PC_VALID = '0;
    doReset();
    for (int cyc = 0; cyc < maxCycles && !done; cyc++) begin
      for (int i = 0; i < NP; i++) begin
        if (!offering[i] && pending[i] > 0 && cyc >= startAt[i] &&
            (!randomGaps || $urandom_range(0, 3) != 0)) begin
          offering[i] = 1'b1;
          curData[i] = {8'(i), 24'(seqNo[i])};
          seqNo[i]++;
          pending[i]--;
        end
        bus.RECEIVE_PC_VALID[i] = offering[i];
        bus.RECEIVE_PC_DATA[i*32 +: 32] = curData[i];
      end
      bus.SEND_PC_READY = randomReady ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge CLK);
      rdy = bus.RECEIVE_PC_READY; sv = bus.SEND_PC_VALID; sr = bus.SEND_PC_READY;
      ss = bus.SEND_PC_SRC; sd = bus.SEND_PC_DATA;
      checkOutput({name, "_ready_onehot"}, 64'($onehot0(rdy)), 64'd1);
      checkOutput({name, "_ready_without_valid"}, rdy & ~bus.RECEIVE_PC_VALID, 0);
      @(posedge CLK);
      if (sv && sr) begin
        checkOutput({name, "_src_has_pending"}, 64'(expQ[ss].size() != 0), 64'd1);
        if (expQ[ss].size() != 0) begin
          expData = expQ[ss].pop_front();
          checkOutput({name, "_data_order"}, sd, expData);
        end
        delivered++;
      end
      for (int i = 0; i < NP; i++) begin
        if (rdy[i]) begin
          expQ[i].push_back(curData[i]);
          offering[i] = 1'b0;
          waitCnt[i] = 0;
        end else if (offering[i] && rdy != 0) begin
          waitCnt[i]++;
          if (waitCnt[i] > maxWait) maxWait = waitCnt[i];
        end
      end
      #1;
      done = (delivered == total);
    end
    checkOutput({name, "_completed"}, 64'(done), 64'd1);
    checkOutput({name, "_delivered"}, delivered, total);
    checkOutput({name, "_max_wait_ok"}, 64'(maxWait <= NP - 1), 64'd1);
    bus.RECEIVE_PC_VALID = '0;
    $display("[TB] %s delivered=%0d maxWait=%0d", name, delivered, maxWait);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RST_N = 1'b1;
    bus.RECEIVE_PC_VALID = '0;
    bus.RECEIVE_PC_DATA = '0;
    bus.SEND_PC_READY = 1'b0;

    // Reset, saturated rotation, backpressure, idle drain, sparse wrap, full-with-stall.
    addVec(0, 4'b1111, 1, 4'b0000, 0, 0, 32'h0,       0);
    addVec(1, 4'b1111, 1, 4'b0001, 1, 0, chanData(0), 1);
    addVec(1, 4'b1111, 1, 4'b0010, 1, 1, chanData(1), 2);
    addVec(1, 4'b1111, 1, 4'b0100, 1, 2, chanData(2), 3);
    addVec(1, 4'b1111, 1, 4'b1000, 1, 3, chanData(3), 0);
    addVec(1, 4'b1111, 1, 4'b0001, 1, 0, chanData(0), 1);
    addVec(1, 4'b1111, 1, 4'b0010, 1, 1, chanData(1), 2);
    for (int k = 0; k < 5; k++) addVec(1, 4'b1111, 0, 4'b0000, 1, 1, chanData(1), 2);
    addVec(1, 4'b1111, 1, 4'b0100, 1, 2, chanData(2), 3);
    addVec(1, 4'b0000, 1, 4'b0000, 0, 2, chanData(2), 3);
    addVec(0, 4'b0000, 1, 4'b0000, 0, 0, 32'h0,       0);
    addVec(1, 4'b0000, 1, 4'b0000, 0, 0, 32'h0,       0);
    addVec(1, 4'b1000, 1, 4'b1000, 1, 3, chanData(3), 0);
    addVec(1, 4'b0010, 1, 4'b0010, 1, 1, chanData(1), 2);
    addVec(1, 4'b0000, 1, 4'b0000, 0, 1, chanData(1), 2);
    addVec(1, 4'b0100, 0, 4'b0100, 1, 2, chanData(2), 3);
    addVec(1, 4'b0001, 0, 4'b0000, 1, 2, chanData(2), 3);
    addVec(1, 4'b0001, 1, 4'b0001, 1, 0, chanData(0), 1);

    #2;
    foreach (vecs[n]) applyStimulus(n, vecs[n]);

    // Reset in the middle of a saturated burst.
    doReset();
    bus.RECEIVE_PC_VALID = 4'b1111;
    bus.SEND_PC_READY = 1'b1;
    for (int i = 0; i < NP; i++) bus.RECEIVE_PC_DATA[i*32 +: 32] = chanData(i);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      checkOutput($sformatf("burst_src%0d", k), bus.SEND_PC_SRC, k);
    end
    RST_N = 1'b0;
    #1;
    checkOutput("midreset_valid", bus.SEND_PC_VALID, 0);
    checkOutput("midreset_src", bus.SEND_PC_SRC, 0);
    checkOutput("midreset_data", bus.SEND_PC_DATA, 0);
    checkOutput("midreset_ready", bus.RECEIVE_PC_READY, 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    #1;
    checkOutput("postreset_ready", bus.RECEIVE_PC_READY, 4'b0001);
    @(posedge CLK);
    #1;
    checkOutput("postreset_valid", bus.SEND_PC_VALID, 1);
    checkOutput("postreset_src", bus.SEND_PC_SRC, 0);
    checkOutput("postreset_data", bus.SEND_PC_DATA, chanData(0));
    @(posedge CLK);
    #1;
    checkOutput("postreset_src_next", bus.SEND_PC_SRC, 1);
    bus.RECEIVE_PC_VALID = '0;

    // Channel 0 hogs, channel 2 shows up at a random cycle.
    pending = '{16, 0, 1, 0};
    startAt = '{0, 0, int'($urandom_range(2, 9)), 0};
    runTraffic("fairness", 200, 1'b0, 1'b0);

    pending = '{256, 256, 256, 256};
    startAt = '{0, 0, 0, 0};
    runTraffic("soak", 20000, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/queue_arbiter.md
# queue_arbiter

Round-robin merge point placed in front of the packet `queue`. It collects result packets from up to `NUM_PORTS` producers and forwards one packet per cycle into the queue's receive channel. Every stage uses the codebase's valid/ready packet handshake. It has a single registered output stage, never drops or duplicates a packet, and gives each requester a bounded wait.

## Interface
- `PACKET_WIDTH`, from shared params (not overridden here): width of one packet.
- `NUM_PORTS`, 4: number of input channels; legal range 2..8.
- `PORT_BITS`, 2: index width; must satisfy 2^`PORT_BITS` >= `NUM_PORTS`.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RST_N`  in  1  reset, asynchronous, active-low.
- `RECEIVE_PC_VALID`  in  `NUM_PORTS`  bit i: channel i offers a packet.
- `RECEIVE_PC_DATA`  in  `NUM_PORTS*PACKET_WIDTH`  channel i occupies bits [i*`PACKET_WIDTH` +: `PACKET_WIDTH`].
- `RECEIVE_PC_READY`  out  `NUM_PORTS`  bit i: channel i's packet is taken this cycle.
- `SEND_PC_VALID`  out  1  output register holds a packet.
- `SEND_PC_DATA`  out  `PACKET_WIDTH`  held packet.
- `SEND_PC_READY`  in  1  downstream (queue) accepts.
- `SEND_PC_SRC`  out  `PORT_BITS`  index of the channel that supplied the held packet.

## Operation
- State:
  - output register `{valid, data, src}`;
  - round-robin pointer `ptr` (`PORT_BITS` wide, range 0..`NUM_PORTS`-1).
- Load enable: `load = !SEND_PC_VALID || SEND_PC_READY`.
- Grant selection (combinational): the first i with `RECEIVE_PC_VALID[i]`, searching `ptr`, `ptr`+1, …, wrapping modulo `NUM_PORTS`.
  - `any` = at least one valid input.
- `RECEIVE_PC_READY[g] = load && any` for the granted g only. All other ready bits are 0, so at most one ready bit is ever high.
- On a clock edge with `load`:
  - `valid <= any`;
  - if `any`: `data <= channel g data`, `src <= g`, `ptr <= (g+1) mod NUM_PORTS` (explicit wrap, not power-of-two truncation).
- On an edge without `load`: all state holds. The output is stable while `SEND_PC_VALID && !SEND_PC_READY`.
- `ptr` only moves on an actual grant; idle cycles leave it unchanged.
- Fairness: a channel holding valid is granted within `NUM_PORTS` successive grants.
- Inputs follow the handshake rule: once valid is asserted, data is held until ready. The arbiter relies on this and does not latch any input before its grant.

## Timing
- Reset (`RST_N`=0, async):
  - `SEND_PC_VALID`=0, `SEND_PC_DATA`=0, `SEND_PC_SRC`=0, `ptr`=0;
  - `RECEIVE_PC_READY` forced to all 0 while reset is held, regardless of inputs.
- Latency: a packet accepted at edge t is visible on `SEND_PC_*` after edge t. There is no combinational path from input data to output data.
- Throughput: one packet per cycle when `SEND_PC_READY` is held high.
- `RECEIVE_PC_READY` depends combinationally on `SEND_PC_READY`, `SEND_PC_VALID`, `RECEIVE_PC_VALID` and `ptr`.
- Boundary cases:
  - **Full (output held, downstream stalled):** all ready bits are 0.
  - **Simultaneous drain and fill in the same cycle:** both happen; no bubble.
  - **All inputs idle:** after the current packet drains, `SEND_PC_VALID` drops to 0.
  - **Wrap-around:** a grant at index `NUM_PORTS`-1 sets `ptr` to 0.
  - **Reset asserted mid-transfer:** the held packet is discarded; producers keep their valid/data and are re-arbitrated from `ptr`=0 after release.

## Structure
- `PACKET_WIDTH` and the default `NUM_PORTS` belong in the shared params include. The handshake send/receive bench tasks come from the shared macro include.
- One sub-module, `rr_picker`: combinational.
  - Inputs: request vector and `ptr`.
  - Outputs: `any` and grant index.
  - Reusable by later memory-port arbiters.
- The top level holds the output register, `ptr` and the ready decode.

## Test plan
1. **Reset:** hold `RST_N`=0 with all `RECEIVE_PC_VALID`=4'b1111 -> `RECEIVE_PC_READY`=0, `SEND_PC_VALID`=0, `SEND_PC_SRC`=0.
2. **Saturated round-robin:** all four inputs valid continuously, `SEND_PC_READY`=1 -> `SEND_PC_SRC` sequence is 0,1,2,3,0,1 on consecutive cycles, one packet per cycle, data matching each source.
3. **Backpressure:** `SEND_PC_READY`=0 for 5 cycles with a packet held -> `SEND_PC_DATA` and `SEND_PC_SRC` unchanged and `RECEIVE_PC_READY`=0 throughout. The first cycle with ready=1 drains that packet and loads the next.
4. **Sparse requests and wrap:** only channel 3 valid, then only channel 1 -> grants 3, then 1; `ptr` goes 0->0 (idle)->0 (3 granted, wrap)->2.
5. **Fairness:** channel 0 valid continuously, channel 2 asserts valid at a random cycle -> channel 2 is granted within 4 grants and no packet is lost.
6. **Mid-stream reset and soak:** assert `RST_N` low for one cycle mid-burst -> outputs clear and arbitration restarts at 0. Then run 1024 random packets from 4 sources with random `SEND_PC_READY`, checked against per-source FIFOs in a scoreboard -> all delivered, in order per source.
